// File: rtl/snake_render_engine_if.sv
// snake_render_engine_if
//   Move handshake between game control (master) and the snake render
//   engine (slave). Game control offers a new head cell with an optional
//   grow request. The engine accepts it when move_ready is high.
//
//   Signals:
//     move_valid  master -> slave  new head position offered
//     move_ready  slave  -> master engine can accept a move
//     head_x      master -> slave  new head cell column
//     head_y      master -> slave  new head cell row
//     grow        master -> slave  keep the tail on this move
interface snake_render_engine_if #(
    parameter int COORD_W = 6
) ();
    logic               move_valid;
    logic               move_ready;
    logic [COORD_W-1:0] head_x;
    logic [COORD_W-1:0] head_y;
    logic               grow;

    modport master (
        output move_valid,
        output head_x,
        output head_y,
        output grow,
        input  move_ready
    );

    modport slave (
        input  move_valid,
        input  head_x,
        input  head_y,
        input  grow,
        output move_ready
    );
endinterface

// File: rtl/snake_render_engine.sv
// snake_render_engine
//   Holds the snake body in a circular segment buffer and renders one VGA
//   pixel per pix_en strobe through a 2-stage pipeline.
//
//   Move path (every clk): IDLE -> CHECK -> COMMIT, one move per 3 clks.
//   CHECK compares the latched head against the live body. COMMIT pushes
//   the head into the buffer and pulses hit on a self-collision.
//
//   Render path (only on pix_en):
//     S1: pixel -> cell coordinates, border flag, mode bits.
//     S2: body/food match, colour register.
//
//   Ports:
//     clk, rst_n         clock, synchronous active-low reset
//     pix_en             pixel-rate enable
//     x, y               current pixel column/row
//     mv                 move handshake (slave modport)
//     food_x, food_y     food cell
//     over, win          mode inputs (both high or both low = play)
//     len                current live length
//     hit                one-clk collision pulse, high during COMMIT
//     full               len == MAX_LEN
//     c_red/green/blue   pixel colour
//
//   Optional feature macro: HEAD_HILITE_EN
//     When defined, the head cell renders yellow (110) above body and food.
module snake_render_engine #(
    parameter int MAX_LEN = 16,
    parameter int GRID_W  = 16,
    parameter int GRID_H  = 16,
    parameter int CELL_W  = 40,
    parameter int CELL_H  = 30,
    parameter int COORD_W = 6,
    parameter int PIX_W   = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      pix_en,
    input  logic [PIX_W-1:0]          x,
    input  logic [PIX_W-1:0]          y,
    snake_render_engine_if.slave      mv,
    input  logic [COORD_W-1:0]        food_x,
    input  logic [COORD_W-1:0]        food_y,
    input  logic                      over,
    input  logic                      win,
    output logic [$clog2(MAX_LEN):0]  len,
    output logic                      hit,
    output logic                      full,
    output logic                      c_red,
    output logic                      c_green,
    output logic                      c_blue
);

    localparam int PTR_W = $clog2(MAX_LEN);
    localparam int LEN_W = PTR_W + 1;
    // Cell comparisons happen at the wider of the two coordinate widths so
    // that an off-grid segment can never alias onto a visible cell.
    localparam int CMP_W = (PIX_W > COORD_W) ? PIX_W : COORD_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_COMMIT
    } move_state_t;

    move_state_t        state;
    logic [PTR_W-1:0]   ptr;
    logic [COORD_W-1:0] seg_x [MAX_LEN];
    logic [COORD_W-1:0] seg_y [MAX_LEN];
    logic [COORD_W-1:0] lat_x;
    logic [COORD_W-1:0] lat_y;
    logic               lat_grow;

    logic [PTR_W-1:0]   ptr_next;
    logic               can_grow;
    logic [MAX_LEN-1:0] live;
    logic [MAX_LEN-1:0] is_tail;
    logic               hit_c;

    // Distance of buffer slot idx behind the head slot p, modulo MAX_LEN.
    // Works for non-power-of-two depths, so the wrap is done explicitly.
    function automatic logic [LEN_W-1:0] seg_age(input logic [PTR_W-1:0] p,
                                                 input int idx);
        logic [LEN_W-1:0] pe;
        logic [LEN_W-1:0] ie;
        pe = {1'b0, p};
        ie = LEN_W'(idx);
        if (pe >= ie)
            return pe - ie;
        else
            return pe + LEN_W'(MAX_LEN) - ie;
    endfunction

    assign ptr_next = (ptr == PTR_W'(MAX_LEN - 1)) ? '0 : ptr + 1'b1;
    // Growing while already full is ignored: the tail drops as usual.
    assign can_grow = lat_grow && (len < LEN_W'(MAX_LEN));

    always_comb begin
        live    = '0;
        is_tail = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            live[i]    = seg_age(ptr, i) < len;
            is_tail[i] = seg_age(ptr, i) == (len - 1'b1);
        end
    end

    // The tail slot is vacated by this move unless it grows, so the head may
    // legally step into it.
    always_comb begin
        hit_c = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (live[i] && !(is_tail[i] && !can_grow) &&
                seg_x[i] == lat_x && seg_y[i] == lat_y)
                hit_c = 1'b1;
        end
    end

    // Move FSM and segment buffer. A reset mid-move discards the latched
    // move and reinitialises the snake to a single centre segment.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            mv.move_ready <= 1'b1;
            hit           <= 1'b0;
            full          <= 1'b0;
            len           <= LEN_W'(1);
            ptr           <= '0;
            seg_x[0]      <= COORD_W'(GRID_W / 2);
            seg_y[0]      <= COORD_W'(GRID_H / 2);
            lat_x         <= '0;
            lat_y         <= '0;
            lat_grow      <= 1'b0;
        end else begin
            hit <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mv.move_valid) begin
                        lat_x         <= mv.head_x;
                        lat_y         <= mv.head_y;
                        lat_grow      <= mv.grow;
                        mv.move_ready <= 1'b0;
                        state         <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    hit   <= hit_c;
                    state <= S_COMMIT;
                end
                S_COMMIT: begin
                    ptr             <= ptr_next;
                    seg_x[ptr_next] <= lat_x;
                    seg_y[ptr_next] <= lat_y;
                    if (can_grow) begin
                        len  <= len + 1'b1;
                        full <= (len + 1'b1) == LEN_W'(MAX_LEN);
                    end
                    mv.move_ready <= 1'b1;
                    state         <= S_IDLE;
                end
                default: begin
                    mv.move_ready <= 1'b1;
                    state         <= S_IDLE;
                end
            endcase
        end
    end

    // ---------------- Render pipeline ----------------
    logic [PIX_W-1:0] cx_c;
    logic [PIX_W-1:0] cy_c;
    logic             border_c;

    logic             s1_valid;
    logic [PIX_W-1:0] s1_cx;
    logic [PIX_W-1:0] s1_cy;
    logic             s1_border;
    logic             s1_over;
    logic             s1_win;

    logic             body_c;
    logic             food_c;
    logic [2:0]       colour_c;

    assign cx_c     = x / PIX_W'(CELL_W);
    assign cy_c     = y / PIX_W'(CELL_H);
    assign border_c = (cx_c == '0) || (cx_c == PIX_W'(GRID_W - 1)) ||
                      (cy_c == '0) || (cy_c == PIX_W'(GRID_H - 1));

    // S2 reads the buffer as it stands this clk; a COMMIT mid-frame may
    // tear one frame, which is harmless.
    always_comb begin
        body_c = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (live[i] &&
                CMP_W'(s1_cx) == CMP_W'(seg_x[i]) &&
                CMP_W'(s1_cy) == CMP_W'(seg_y[i]))
                body_c = 1'b1;
        end
    end

    assign food_c = (CMP_W'(s1_cx) == CMP_W'(food_x)) &&
                    (CMP_W'(s1_cy) == CMP_W'(food_y));

`ifdef HEAD_HILITE_EN
    logic head_c;
    assign head_c = (CMP_W'(s1_cx) == CMP_W'(seg_x[ptr])) &&
                    (CMP_W'(s1_cy) == CMP_W'(seg_y[ptr]));
`endif

    // Equal mode bits (both set or both clear) fall through to play mode.
    always_comb begin
        colour_c = 3'b001;
        if (s1_border)
            colour_c = 3'b000;
        else if (s1_over && !s1_win)
            colour_c = 3'b100;
        else if (s1_win && !s1_over)
            colour_c = 3'b010;
`ifdef HEAD_HILITE_EN
        else if (head_c)
            colour_c = 3'b110;
`endif
        else if (body_c)
            colour_c = 3'b111;
        else if (food_c)
            colour_c = 3'b010;
    end

    // Both stages advance only on pix_en, so the colour holds between
    // strobes. The colour register is stage 2.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid  <= 1'b0;
            s1_cx     <= '0;
            s1_cy     <= '0;
            s1_border <= 1'b0;
            s1_over   <= 1'b0;
            s1_win    <= 1'b0;
            c_red     <= 1'b0;
            c_green   <= 1'b0;
            c_blue    <= 1'b0;
        end else if (pix_en) begin
            s1_valid  <= 1'b1;
            s1_cx     <= cx_c;
            s1_cy     <= cy_c;
            s1_border <= border_c;
            s1_over   <= over;
            s1_win    <= win;
            if (s1_valid)
                {c_red, c_green, c_blue} <= colour_c;
        end
    end

endmodule

// File: tb/tb_snake_render_engine.sv
// tb_snake_render_engine
//   Directed bench for snake_render_engine. dut1 uses the default depth
//   (16), dut2 uses MAX_LEN=4 to exercise the full/wrap behaviour. Both
//   share the pixel and mode inputs; each has its own move interface.
module tb_snake_render_engine;

    localparam int PIX_W   = 10;
    localparam int COORD_W = 6;

`ifdef HEAD_HILITE_EN
    localparam logic [2:0] HEAD_COL = 3'b110;
`else
    localparam logic [2:0] HEAD_COL = 3'b111;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               pix_en;
    logic [PIX_W-1:0]   x;
    logic [PIX_W-1:0]   y;
    logic [COORD_W-1:0] food_x;
    logic [COORD_W-1:0] food_y;
    logic               over;
    logic               win;

    logic [4:0] len1;
    logic       hit1, full1, r1, g1, b1;
    logic [2:0] len2;
    logic       hit2, full2, r2, g2, b2;
    logic [2:0] col1, col2;

    assign col1 = {r1, g1, b1};
    assign col2 = {r2, g2, b2};

    always #5 clk = ~clk;

    snake_render_engine_if #(.COORD_W(COORD_W)) mv1 ();
    snake_render_engine_if #(.COORD_W(COORD_W)) mv2 ();

    snake_render_engine #(.MAX_LEN(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(x), .y(y), .mv(mv1),
        .food_x(food_x), .food_y(food_y), .over(over), .win(win),
        .len(len1), .hit(hit1), .full(full1),
        .c_red(r1), .c_green(g1), .c_blue(b1)
    );

    snake_render_engine #(.MAX_LEN(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(x), .y(y), .mv(mv2),
        .food_x(food_x), .food_y(food_y), .over(over), .win(win),
        .len(len2), .hit(hit2), .full(full2),
        .c_red(r2), .c_green(g2), .c_blue(b2)
    );

    int n_checks = 0;
    int n_passed = 0;
    int n_failed = 0;

    // Handshake observations from the last applyMove call.
    logic rdy_check, rdy_commit, rdy_after;
    logic hit_check, hit_commit, hit_after;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) n_passed++;
        else begin
            n_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Offer one move to dut1 (which=1) or dut2 (which=2) and record
    // move_ready/hit on the CHECK, COMMIT and following cycles.
    task automatic applyMove(input int which, input int hx, input int hy, input logic g);
        int wait_cycles = 0;
        @(negedge clk);
        while (((which == 1) ? mv1.move_ready : mv2.move_ready) !== 1'b1 && wait_cycles < 10) begin
            @(negedge clk);
            wait_cycles++;
        end
        if (wait_cycles >= 10)
            checkOutput("move_ready_timeout", 32'd0, 32'd1);
        if (which == 1) begin
            mv1.move_valid = 1'b1;
            mv1.head_x     = COORD_W'(hx);
            mv1.head_y     = COORD_W'(hy);
            mv1.grow       = g;
        end else begin
            mv2.move_valid = 1'b1;
            mv2.head_x     = COORD_W'(hx);
            mv2.head_y     = COORD_W'(hy);
            mv2.grow       = g;
        end
        @(negedge clk);
        mv1.move_valid = 1'b0;
        mv2.move_valid = 1'b0;
        rdy_check  = (which == 1) ? mv1.move_ready : mv2.move_ready;
        hit_check  = (which == 1) ? hit1 : hit2;
        @(negedge clk);
        rdy_commit = (which == 1) ? mv1.move_ready : mv2.move_ready;
        hit_commit = (which == 1) ? hit1 : hit2;
        @(negedge clk);
        rdy_after  = (which == 1) ? mv1.move_ready : mv2.move_ready;
        hit_after  = (which == 1) ? hit1 : hit2;
    endtask

    // Two back-to-back strobes with the pixel held: the colour for (px,py)
    // is in the output register afterwards.
    task automatic applyPixel(input int px, input int py);
        @(negedge clk);
        x      = PIX_W'(px);
        y      = PIX_W'(py);
        pix_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        pix_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        pix_en         = 1'b0;
        x              = '0;
        y              = '0;
        food_x         = 6'd11;
        food_y         = 6'd8;
        over           = 1'b0;
        win            = 1'b0;
        mv1.move_valid = 1'b0;
        mv1.head_x     = '0;
        mv1.head_y     = '0;
        mv1.grow       = 1'b0;
        mv2.move_valid = 1'b0;
        mv2.head_x     = '0;
        mv2.head_y     = '0;
        mv2.grow       = 1'b0;

        repeat (3) @(negedge clk);
        checkOutput("reset_ready", 32'(mv1.move_ready), 32'd1);
        checkOutput("reset_len", 32'(len1), 32'd1);
        checkOutput("reset_hit", 32'(hit1), 32'd0);
        checkOutput("reset_full", 32'(full1), 32'd0);
        checkOutput("reset_colour", 32'(col1), 32'd0);
        checkOutput("reset_len_small", 32'(len2), 32'd1);
        rst_n = 1'b1;

        // Single centre segment
        applyPixel(320, 240);
        checkOutput("centre_head", 32'(col1), 32'(HEAD_COL));

        // Grow twice along row 8
        applyMove(1, 9, 8, 1'b1);
        checkOutput("grow1_len", 32'(len1), 32'd2);
        checkOutput("grow1_rdy_check", 32'(rdy_check), 32'd0);
        checkOutput("grow1_rdy_commit", 32'(rdy_commit), 32'd0);
        checkOutput("grow1_rdy_after", 32'(rdy_after), 32'd1);
        applyMove(1, 10, 8, 1'b1);
        checkOutput("grow2_len", 32'(len1), 32'd3);
        applyPixel(400, 240);
        checkOutput("head_10_8", 32'(col1), 32'(HEAD_COL));
        applyPixel(360, 240);
        checkOutput("body_9_8", 32'(col1), 32'd7);
        applyPixel(440, 240);
        checkOutput("food_11_8", 32'(col1), 32'd2);

        // Plain move: tail (8,8) drops
        applyMove(1, 11, 8, 1'b0);
        checkOutput("move_len", 32'(len1), 32'd3);
        checkOutput("move_rdy_check", 32'(rdy_check), 32'd0);
        checkOutput("move_rdy_commit", 32'(rdy_commit), 32'd0);
        checkOutput("move_rdy_after", 32'(rdy_after), 32'd1);
        checkOutput("move_hit", 32'(hit_commit), 32'd0);
        applyPixel(320, 240);
        checkOutput("dropped_8_8", 32'(col1), 32'd1);
        applyPixel(440, 240);
        checkOutput("head_on_food", 32'(col1), 32'(HEAD_COL));

        // Head into tail without growth: tail vacates, no hit
        applyMove(1, 9, 8, 1'b0);
        checkOutput("tail_nogrow_hit", 32'(hit_commit), 32'd0);
        checkOutput("tail_nogrow_len", 32'(len1), 32'd3);

        // Head into tail with growth: tail stays, hit
        applyMove(1, 10, 8, 1'b1);
        checkOutput("tail_grow_hit", 32'(hit_commit), 32'd1);
        checkOutput("tail_grow_len", 32'(len1), 32'd4);

        // Head into a mid-body cell: one-clk hit in COMMIT only
        applyMove(1, 11, 8, 1'b0);
        checkOutput("loop_hit_check", 32'(hit_check), 32'd0);
        checkOutput("loop_hit_commit", 32'(hit_commit), 32'd1);
        checkOutput("loop_hit_after", 32'(hit_after), 32'd0);
        checkOutput("loop_len", 32'(len1), 32'd4);
        checkOutput("loop_full", 32'(full1), 32'd0);

        // Mode colouring
        over = 1'b1;
        applyPixel(320, 240);
        checkOutput("over_screen", 32'(col1), 32'd4);
        applyPixel(10, 10);
        checkOutput("over_border", 32'(col1), 32'd0);
        win = 1'b1;
        applyPixel(440, 240);
        checkOutput("both_head", 32'(col1), 32'(HEAD_COL));
        applyPixel(400, 240);
        checkOutput("both_body", 32'(col1), 32'd7);
        applyPixel(320, 240);
        checkOutput("both_background", 32'(col1), 32'd1);
        over = 1'b0;
        applyPixel(440, 240);
        checkOutput("win_screen", 32'(col1), 32'd2);
        win = 1'b0;
        applyPixel(639, 479);
        checkOutput("border_far_corner", 32'(col1), 32'd0);
        applyPixel(600, 240);
        checkOutput("border_right", 32'(col1), 32'd0);
        applyPixel(360, 240);
        checkOutput("play_body", 32'(col1), 32'd7);

        // Output holds without strobes
        x = '0;
        y = '0;
        repeat (3) @(negedge clk);
        checkOutput("hold_colour", 32'(col1), 32'd7);

        // MAX_LEN=4: five grows, ptr wraps, oldest dropped
        applyMove(2, 9, 8, 1'b1);
        applyMove(2, 10, 8, 1'b1);
        checkOutput("small_len3", 32'(len2), 32'd3);
        checkOutput("small_notfull", 32'(full2), 32'd0);
        applyMove(2, 11, 8, 1'b1);
        checkOutput("small_len4", 32'(len2), 32'd4);
        checkOutput("small_full", 32'(full2), 32'd1);
        applyMove(2, 12, 8, 1'b1);
        applyMove(2, 13, 8, 1'b1);
        checkOutput("small_len_capped", 32'(len2), 32'd4);
        checkOutput("small_still_full", 32'(full2), 32'd1);
        applyPixel(360, 240);
        checkOutput("small_dropped_9", 32'(col2), 32'd1);
        applyPixel(320, 240);
        checkOutput("small_dropped_8", 32'(col2), 32'd1);
        applyPixel(400, 240);
        checkOutput("small_tail_10", 32'(col2), 32'd7);
        applyPixel(520, 240);
        checkOutput("small_head_13", 32'(col2), 32'(HEAD_COL));

        // Grow into tail while full: grow ignored, tail drops, no hit
        applyMove(2, 10, 8, 1'b1);
        checkOutput("small_full_tail_hit", 32'(hit_commit), 32'd0);
        checkOutput("small_full_tail_len", 32'(len2), 32'd4);
        applyPixel(400, 240);
        checkOutput("small_new_head", 32'(col2), 32'(HEAD_COL));
        applyPixel(440, 240);
        checkOutput("small_body_11", 32'(col2), 32'd7);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule
